// File: rtl/data_memory_pkg.sv
// Shared widths and types for the MEM-stage data memory.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package data_memory_pkg;

  localparam int DATA_W        = 32;
  localparam int ADDR_W        = 32;
  localparam int DEFAULT_DEPTH = 256;

  typedef logic [DATA_W-1:0] word_t;

endpackage : data_memory_pkg

// File: rtl/data_memory.sv
// Word-addressed single-port data memory: sync write, combinational read, async clear.
// Latency: read 0 cycles, write visible after the capturing rising edge.
// Backpressure: none; accepts one access every cycle. Optional DATA_MEMORY_ADDR_ERR_EN adds addr_err.
module data_memory #(
  parameter int DEPTH  = data_memory_pkg::DEFAULT_DEPTH,
  parameter int DATA_W = data_memory_pkg::DATA_W
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [data_memory_pkg::ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]                data_in,
  input  logic                             we,
  output logic [DATA_W-1:0]                data_out
`ifdef DATA_MEMORY_ADDR_ERR_EN
  ,
  output logic                             addr_err
`endif
);

  import data_memory_pkg::*;

  // DEPTH is a power of two >= 2, so the low IDX_W bits index the array
  // once the full-width range check has passed.
  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  // Full 32-bit compare: addresses at or above DEPTH never alias onto low words.
  assign in_range = (addr < ADDR_W'(DEPTH));
  assign idx      = addr[IDX_W-1:0];

  // Storage: cleared asynchronously on reset, written only for in-range addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we && in_range) begin
      mem[idx] <= data_in;
    end
  end

  // Read path: purely combinational, zero when out of range or in reset.
  always_comb begin
    data_out = '0;
    if (rst_n && in_range) begin
      data_out = mem[idx];
    end
  end

`ifdef DATA_MEMORY_ADDR_ERR_EN
  // Out-of-range flag, held low while reset is asserted.
  always_comb begin
    addr_err = 1'b0;
    if (rst_n && !in_range) begin
      addr_err = 1'b1;
    end
  end
`endif

endmodule : data_memory

// File: tb/tb_data_memory.sv
// Directed bench for data_memory with a queue-based scoreboard.
// Latency: reads checked 1 time unit after addr settles; writes after the capturing edge.
// Backpressure: n/a; the monitor drains one expectation per check strobe.
module tb_data_memory;

  localparam int DEPTH = 256;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic        we;
  logic [31:0] data_out;
`ifdef DATA_MEMORY_ADDR_ERR_EN
  logic        addr_err;
`endif

  exp_t sb_q[$];
  exp_t cur;
  event chk_ev;
  int   n_chk;
  int   n_fail;

  data_memory #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .data_in  (data_in),
    .we       (we),
    .data_out (data_out)
`ifdef DATA_MEMORY_ADDR_ERR_EN
    ,
    .addr_err (addr_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: each strobe pops the oldest expectation and compares the live outputs.
  always begin
    @(chk_ev);
    if (sb_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_underflow: strobe with empty queue");
    end else begin
      cur = sb_q.pop_front();
      n_chk++;
      if (data_out !== cur.data) begin
        n_fail++;
        $display("FAIL %s: data_out=%h expected=%h", cur.name, data_out, cur.data);
      end
`ifdef DATA_MEMORY_ADDR_ERR_EN
      n_chk++;
      if (addr_err !== cur.err) begin
        n_fail++;
        $display("FAIL %s_err: addr_err=%b expected=%b", cur.name, addr_err, cur.err);
      end
`endif
    end
  end

  // Drive an address, let it settle, queue the expectation and strobe the monitor.
  task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic e, input string nm);
    exp_t x;
    addr = a;
    #1;
    x.name = nm;
    x.data = d;
    x.err  = e;
    sb_q.push_back(x);
    -> chk_ev;
    #1;
  endtask

  // Single write on the next rising edge; returns 1 time unit after it.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr    = a;
    data_in = d;
    we      = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    addr    = '0;
    data_in = 32'hFFFF_FFFF;
    we      = 1'b1;   // writes must be blocked while in reset

    // Reset: everything reads zero, including across a clock edge with we=1.
    for (int i = 0; i < 5; i++) rd(32'(i), 32'h0, 1'b0, $sformatf("rst_rd%0d", i));
    we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) rd(32'(i), 32'h0, 1'b0, $sformatf("post_rst_rd%0d", i));

    // Write/readback of 56000 at words 0..4; word 5 untouched.
    @(negedge clk);
    for (int i = 0; i < 5; i++) wr(32'(i), 32'd56000);
    for (int i = 0; i < 5; i++) rd(32'(i), 32'd56000, 1'b0, $sformatf("wb_rd%0d", i));
    rd(32'd5, 32'h0, 1'b0, "wb_rd5_empty");

    // Write disable: several edges with we=0 leave word 2 intact.
    addr    = 32'd2;
    data_in = 32'd12345;
    we      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rd(32'd2, 32'd56000, 1'b0, "we_off");

    // Read-during-write: old value before the edge, new value after.
    @(posedge clk);
    #1;
    addr    = 32'd3;
    data_in = 32'hDEAD_BEEF;
    we      = 1'b1;
    rd(32'd3, 32'd56000, 1'b0, "rdw_before");
    @(posedge clk);
    #1;
    we = 1'b0;
    rd(32'd3, 32'hDEAD_BEEF, 1'b0, "rdw_after");

    // Out of range: no write, zero read, no aliasing onto word 0.
    wr(32'd256, 32'hA5A5_A5A5);
    rd(32'd256, 32'h0, 1'b1, "oor_256");
    rd(32'd0, 32'd56000, 1'b0, "oor_256_word0");
    wr(32'h8000_0100, 32'h5A5A_5A5A);
    rd(32'h8000_0100, 32'h0, 1'b1, "oor_hi");
    rd(32'd0, 32'd56000, 1'b0, "oor_hi_word0");
    wr(32'h8000_0003, 32'h1234_5678);
    rd(32'd3, 32'hDEAD_BEEF, 1'b0, "oor_hi3_word3");
    rd(32'd255, 32'h0, 1'b0, "last_word_empty");
    wr(32'd255, 32'hCAFE_F00D);
    rd(32'd255, 32'hCAFE_F00D, 1'b0, "last_word");

    // Repeated writes to one address: last wins; back-to-back differing addresses.
    wr(32'd7, 32'h1111_1111);
    wr(32'd7, 32'h2222_2222);
    wr(32'd8, 32'h3333_3333);
    rd(32'd7, 32'h2222_2222, 1'b0, "last_wins");
    rd(32'd8, 32'h3333_3333, 1'b0, "b2b_8");

    // Mid-operation reset between edges: output drops with no clock edge.
    @(posedge clk);
    #1;
    rd(32'd0, 32'd56000, 1'b0, "mid_pre");
    rst_n = 1'b0;
    rd(32'd0, 32'h0, 1'b0, "mid_async");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) rd(32'(i), 32'h0, 1'b0, $sformatf("mid_after%0d", i));

    // Scoreboard must be fully drained.
    #2;
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_data_memory
